// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the 16-bit RISC core.  It reads the current PC,
// issues a request/acknowledge read to instruction memory, and buffers the
// returned {pc, instr} pairs in a small circular FIFO for decode.  It steers
// the PC unit through a 2-bit control word and a latched load target, and it
// handles branch flushes.  A flush never abandons a memory request: if the
// request is still open, the response is waited for and then thrown away.
//
// Ports
//   i_clk, i_rst          clock (posedge), asynchronous active-high reset
//   i_pc                  current PC from the PC unit (it updates on negedge)
//   o_pc_ctrl             PC unit control: 00 hold, 01 +1, 10 load, 11 clear
//   o_pc_target           latched branch target for the PC unit load
//   i_flush               single-cycle branch-taken pulse from execute
//   i_flush_target        branch target, sampled only while i_flush=1
//   o_imem_req/o_imem_addr  memory read request and address
//   i_imem_ack/i_imem_rdata memory read data valid and instruction word
//   o_instr_valid/o_instr/o_instr_pc  FIFO head toward decode
//   i_instr_ready         decode accepts the head
//   o_dbg_state           current FSM state encoding, for observation
//
// Handshakes
//   Decode side: the head transfers on a posedge where o_instr_valid and
//   i_instr_ready are both 1.  While o_instr_valid=1 and i_instr_ready=0 the
//   head (o_instr, o_instr_pc) holds still.  Memory side: o_imem_req stays 1
//   with a constant o_imem_addr until the posedge that samples i_imem_ack=1;
//   ack may arrive in the same cycle as the request or in any later cycle.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pc,
    output logic [1:0]        o_pc_ctrl,
    output logic [DATA_W-1:0] o_pc_target,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_flush_target,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_instr_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_instr_pc,
    input  logic              i_instr_ready,
    output logic [2:0]        o_dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_RST        = 3'd0,
        S_REQ        = 3'd1,
        S_ADV        = 3'd2,
        S_WAIT_SPACE = 3'd3,
        S_DROP       = 3'd4,
        S_LOAD       = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

    logic             capture_addr;
    logic             flush_act;
    logic             push;
    logic             pop;
    logic             slot_free;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [DATA_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];

    // Flushes are ignored while the PC unit is still being cleared.
    assign flush_act = i_flush && (state != S_RST);

    assign o_instr_valid = (count != '0);
    // A flush discards whatever decode takes in the same cycle.
    assign pop  = o_instr_valid && i_instr_ready && !flush_act;
    assign push = (state == S_REQ) && i_imem_ack && !flush_act;
    // A slot counts as free if this cycle's pop makes room.
    assign slot_free = (count < DEPTH_C) || pop;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        next_state   = state;
        capture_addr = 1'b0;
        case (state)
            S_RST: begin
                next_state   = S_REQ;
                capture_addr = 1'b1;
            end
            S_REQ: begin
                if (flush_act) begin
                    next_state = i_imem_ack ? S_LOAD : S_DROP;
                end else if (i_imem_ack) begin
                    next_state = S_ADV;
                end
            end
            S_ADV, S_LOAD: begin
                if (flush_act) begin
                    next_state = S_LOAD;
                end else if (slot_free) begin
                    next_state   = S_REQ;
                    capture_addr = 1'b1;
                end else begin
                    next_state = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (flush_act) begin
                    next_state = S_LOAD;
                end else if (slot_free) begin
                    next_state   = S_REQ;
                    capture_addr = 1'b1;
                end
            end
            S_DROP: begin
                // The open request must complete; its data is discarded.
                if (i_imem_ack) begin
                    next_state = S_LOAD;
                end
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        o_pc_ctrl  = 2'b00;
        o_imem_req = 1'b0;
        case (state)
            S_RST:  o_pc_ctrl  = 2'b11;
            S_ADV:  o_pc_ctrl  = 2'b01;
            S_LOAD: o_pc_ctrl  = 2'b10;
            S_REQ:  o_imem_req = 1'b1;
            S_DROP: o_imem_req = 1'b1;
            default: begin
                o_pc_ctrl  = 2'b00;
                o_imem_req = 1'b0;
            end
        endcase
    end

    assign o_dbg_state = state;

    // Request address and branch target registers.  i_pc is settled at every
    // posedge because the PC unit acts on the preceding negedge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_imem_addr <= '0;
            o_pc_target <= '0;
        end else begin
            if (capture_addr) begin
                o_imem_addr <= i_pc;
            end
            if (flush_act) begin
                o_pc_target <= i_flush_target;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_act) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are gated by valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= o_imem_addr;
            instr_mem[wr_ptr] <= i_imem_rdata;
        end
    end

    assign o_instr    = o_instr_valid ? instr_mem[rd_ptr] : '0;
    assign o_instr_pc = o_instr_valid ? pc_mem[rd_ptr]    : '0;

endmodule
